// File: rtl/zed_io_pkg.sv
// zed_io_pkg: shared types and constants for the zed_io pin conditioning blocks
// Contents:
//   io_state_t     - output shaper phase states (IDLE/HOLD/PULSE/GAP)
//   DEB_TIME_W     - width of the hold/debounce time field in 100 us units
//   DEF_TIME_TICK  - default clocks per time unit (100 us at 100 MHz)
package zed_io_pkg;
    localparam int DEB_TIME_W    = 5;
    localparam int DEF_TIME_TICK = 10000;
    typedef enum logic [1:0] {IDLE, HOLD, PULSE, GAP} io_state_t;
endpackage

// File: rtl/io_tick_gen.sv
// io_tick_gen: clearable prescaler emitting a one-cycle wrap every TIME_TICK clocks
// Ports:
//   clk  - system clock
//   res  - synchronous reset, active-high
//   clr  - holds the counter at 0 while asserted
//   wrap - high during the last count (TIME_TICK-1) of each time unit
// Parameters: TIME_TICK (>= 2) clocks per unit, TICK_W counter width (2^TICK_W > TIME_TICK)
module io_tick_gen
    import zed_io_pkg::*;
#(
    parameter int TIME_TICK = DEF_TIME_TICK,
    parameter int TICK_W    = 16
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    output logic wrap
);
    logic [TICK_W-1:0] cnt;

    assign wrap = !clr && (cnt == TICK_W'(TIME_TICK - 1));

    always_ff @(posedge clk) begin
        if (res || clr)
            cnt <= '0;
        else
            cnt <= wrap ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/output_shaper.sv
// output_shaper: holds every data_out transition for a programmable minimum time, with optional pulse mode
// Ports:
//   clk        - system clock (100 MHz expected)
//   res        - synchronous reset, active-high
//   ena        - enable; 0 bypasses data_in straight to data_out
//   hold_time  - minimum stable time, (hold_time+1) units of TIME_TICK clocks
//   pulse_mode - 0 level mode, 1 pulse mode (sampled only while idle)
//   data_in    - requested level (level mode) / idle level (pulse mode)
//   trig       - single-cycle pulse request (pulse mode only)
//   data_out   - shaped output
//   busy       - high while a hold, pulse or gap is in progress
// Build option: OUTPUT_SHAPER_TRIG_QUEUE_EN adds a 1-entry pending trigger
module output_shaper
    import zed_io_pkg::*;
#(
    parameter int TIME_TICK = DEF_TIME_TICK,
    parameter int TICK_W    = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  ena,
    input  logic [DEB_TIME_W-1:0] hold_time,
    input  logic                  pulse_mode,
    input  logic                  data_in,
    input  logic                  trig,
    output logic                  data_out,
    output logic                  busy
);
    io_state_t             state;
    logic                  out_s;
    logic [DEB_TIME_W-1:0] unit;
    logic [DEB_TIME_W-1:0] hold_lat;
    logic                  wrap;
    logic                  pending;
    logic                  phase_end;
    logic                  misalign;
    logic                  fire;

    io_tick_gen #(
        .TIME_TICK(TIME_TICK),
        .TICK_W   (TICK_W)
    ) u_tick (
        .clk (clk),
        .res (res),
        .clr (state == IDLE || !ena),
        .wrap(wrap)
    );

    // unit is compared before incrementing, so hold_lat=31 never overflows it
    assign phase_end = wrap && (unit == hold_lat);
    assign misalign  = data_in != out_s;
    // re-aligning to data_in takes priority over starting a pulse
    assign fire      = pulse_mode && !misalign && (trig || pending);
    assign data_out  = ena ? out_s : data_in;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= IDLE;
            unit     <= '0;
            hold_lat <= '0;
            out_s    <= 1'b0;
        end else if (!ena) begin
            // tracking data_in while bypassed makes re-enabling edge-free
            state <= IDLE;
            unit  <= '0;
            out_s <= data_in;
        end else begin
            if (wrap)
                unit <= phase_end ? '0 : unit + 1'b1;
            case (state)
                IDLE: begin
                    if (misalign) begin
                        out_s    <= data_in;
                        hold_lat <= hold_time;
                        state    <= HOLD;
                    end else if (fire) begin
                        out_s    <= ~data_in;
                        hold_lat <= hold_time;
                        state    <= PULSE;
                    end
                end
                HOLD:  if (phase_end) state <= IDLE;
                // the gap reuses the pulse width so spacing is at least one pulse
                PULSE: if (phase_end) begin
                    out_s <= data_in;
                    state <= GAP;
                end
                GAP:   if (phase_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OUTPUT_SHAPER_TRIG_QUEUE_EN
    always_ff @(posedge clk) begin
        if (res || !ena)
            pending <= 1'b0;
        else if (state == IDLE)
            pending <= pulse_mode && misalign && pending;
        else if (trig && pulse_mode)
            pending <= 1'b1;
    end
`else
    assign pending = 1'b0;
`endif
endmodule
